cache_way_flush: RTL and testbench

CACHE_WAY_FLUSH -- requirements
Module: cache_way_flush

---
 rtl/cache_way_flush_pkg.sv | 22 ++
 rtl/cache_way_flush_sram.sv | 31 +++
 rtl/cache_way_flush.sv | 207 ++++++++++++++++++++
 tb/tb_cache_way_flush.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_way_flush_pkg.sv
// Shared geometry defaults and helpers for the cache way with flush sequencer.
// FSM encodings are kept local to the modules that own them.
package cache_way_flush_pkg;

   localparam int CACHE_DEPTH     = 256;
   localparam int CACHE_TAG_WIDTH = 20;
   localparam int DATA_WIDTH      = 32;
   localparam int RAM_NUM         = 4;

   // Per-set status bits that travel together on the read path.
   typedef struct packed {
      logic valid;
      logic dirty;
      logic lru;
   } line_meta_t;

   // Address width that stays at least one bit wide for degenerate sizes.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_way_flush_sram.sv
// Single-port synchronous-read RAM, read-first on a same-address write.
// Used for the tag array and for each data word bank.
module cache_sram
   import cache_way_flush_pkg::*;
#(
   parameter int DEPTH = CACHE_DEPTH,
   parameter int WIDTH = DATA_WIDTH,
   localparam int AW   = safe_clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: the storage array and its read register carry no reset, so the
   // tools can map them onto a RAM macro; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_way_flush.sv
// One cache way (tag/data RAMs plus valid/dirty/lru flops) with a flush
// sequencer that either invalidates everything or writes back dirty lines.
module cache_way_flush
   import cache_way_flush_pkg::*;
#(
   parameter int SETS       = CACHE_DEPTH,
   parameter int LINE_WORDS = RAM_NUM,
   parameter int TAG_W      = CACHE_TAG_WIDTH,
   parameter int DATA_W     = DATA_WIDTH,
   localparam int IDX_W     = safe_clog2(SETS),
   localparam int OFF_W     = safe_clog2(LINE_WORDS),
   localparam int LINE_W    = DATA_W * LINE_WORDS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IDX_W-1:0]      index_i,
   input  logic [OFF_W-1:0]      offset_i,
   input  logic                  wr_tag_en_i,
   input  logic                  wr_valid_en_i,
   input  logic                  wr_dirty_en_i,
   input  logic                  wr_lru_en_i,
   input  logic                  wr_full_line_i,
   input  logic [LINE_WORDS-1:0] wr_data_en_i,
   input  logic [TAG_W-1:0]      wr_tag_i,
   input  logic                  wr_valid_i,
   input  logic                  wr_dirty_i,
   input  logic                  wr_lru_i,
   input  logic [LINE_W-1:0]     wr_data_i,
   output logic [TAG_W-1:0]      rd_tag_o,
   output logic                  rd_valid_o,
   output logic                  rd_dirty_o,
   output logic                  rd_lru_o,
   output logic [LINE_W-1:0]     rd_data_o,
   input  logic                  flush_req_i,
   input  logic                  flush_wb_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [IDX_W-1:0]      wb_index_o,
   output logic [TAG_W-1:0]      wb_tag_o,
   output logic [LINE_W-1:0]     wb_data_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_RD,
      S_WB,
      S_DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              wb_mode_q, wb_mode_d;
   logic [SETS-1:0]   valid_q, valid_d;
   logic [SETS-1:0]   dirty_q, dirty_d;
   logic [SETS-1:0]   lru_q, lru_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wb_valid_q, wb_valid_d;
   line_meta_t        rd_meta_q, rd_meta_d;
   logic              advance;

   logic              idle;
   logic [IDX_W-1:0]  ram_addr;
   logic [DATA_W-1:0] word_sel;
   logic [TAG_W-1:0]  tag_rdata;
   logic [LINE_W-1:0] data_rdata;

   assign idle     = (state_q == S_IDLE);
   assign ram_addr = idle ? index_i : cnt_q;
   assign word_sel = wr_data_i[DATA_W*offset_i +: DATA_W];

   cache_sram #(
      .DEPTH (SETS),
      .WIDTH (TAG_W)
   ) u_tag_ram (
      .clk     (clk),
      .we_i    (idle && wr_tag_en_i),
      .addr_i  (ram_addr),
      .wdata_i (wr_tag_i),
      .rdata_o (tag_rdata)
   );

   // Partial writes broadcast the offset-selected word to every flagged bank.
   for (genvar w = 0; w < LINE_WORDS; w++) begin : g_bank
      cache_sram #(
         .DEPTH (SETS),
         .WIDTH (DATA_W)
      ) u_data_ram (
         .clk     (clk),
         .we_i    (idle && (wr_full_line_i || wr_data_en_i[w])),
         .addr_i  (ram_addr),
         .wdata_i (wr_full_line_i ? wr_data_i[w*DATA_W +: DATA_W] : word_sel),
         .rdata_o (data_rdata[w*DATA_W +: DATA_W])
      );
   end

   // NOTE: every always_comb target is defaulted first, so no path through
   // the case statement can leave a value held and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wb_mode_d = wb_mode_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      lru_d     = lru_q;
      advance   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wr_valid_en_i) valid_d[index_i] = wr_valid_i;
            if (wr_dirty_en_i) dirty_d[index_i] = wr_dirty_i;
            if (wr_lru_en_i)   lru_d[index_i]   = wr_lru_i;
            if (flush_req_i) begin
               wb_mode_d = flush_wb_i;
               cnt_d     = '0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            if (!wb_mode_q) begin
               valid_d = '0;
               dirty_d = '0;
               lru_d   = '0;
               state_d = S_DONE;
            end else if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
               state_d = S_RD;
            end else begin
               valid_d[cnt_q] = 1'b0;
               dirty_d[cnt_q] = 1'b0;
               lru_d[cnt_q]   = 1'b0;
               advance        = 1'b1;
            end
         end
         S_RD: state_d = S_WB;
         S_WB: begin
            if (wb_valid_q && wb_ready_i) begin
               valid_d[cnt_q] = 1'b0;
               dirty_d[cnt_q] = 1'b0;
               lru_d[cnt_q]   = 1'b0;
               advance        = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (cnt_q == LAST_SET) begin
            state_d = S_DONE;
         end else begin
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = S_SCAN;
         end
      end

      // Outputs are registered from the next state so they align with it.
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      wb_valid_d = (state_d == S_WB);
      rd_meta_d  = '{valid: valid_q[index_i], dirty: dirty_q[index_i], lru: lru_q[index_i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wb_mode_q  <= 1'b0;
         valid_q    <= '0;
         dirty_q    <= '0;
         lru_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         rd_meta_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_mode_q  <= wb_mode_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         lru_q      <= lru_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wb_valid_q <= wb_valid_d;
         rd_meta_q  <= rd_meta_d;
      end
   end

   assign rd_tag_o   = tag_rdata;
   assign rd_data_o  = data_rdata;
   assign rd_valid_o = rd_meta_q.valid;
   assign rd_dirty_o = rd_meta_q.dirty;
   assign rd_lru_o   = rd_meta_q.lru;

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign wb_valid_o = wb_valid_q;
   assign wb_index_o = cnt_q;
   assign wb_tag_o   = tag_rdata;
   assign wb_data_o  = data_rdata;

endmodule

// File: tb/tb_cache_way_flush.sv
// Directed bench for cache_way_flush: read/write paths, write-back flush,
// invalidate-only flush and reset in the middle of a write-back.
module tb_cache_way_flush;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   index_i;
   logic [1:0]   offset_i;
   logic         wr_tag_en_i, wr_valid_en_i, wr_dirty_en_i, wr_lru_en_i, wr_full_line_i;
   logic [3:0]   wr_data_en_i;
   logic [19:0]  wr_tag_i;
   logic         wr_valid_i, wr_dirty_i, wr_lru_i;
   logic [127:0] wr_data_i;
   logic [19:0]  rd_tag_o;
   logic         rd_valid_o, rd_dirty_o, rd_lru_o;
   logic [127:0] rd_data_o;
   logic         flush_req_i, flush_wb_i, busy_o, done_o;
   logic         wb_valid_o, wb_ready_i;
   logic [7:0]   wb_index_o;
   logic [19:0]  wb_tag_o;
   logic [127:0] wb_data_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_way_flush dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .index_i        (index_i),
      .offset_i       (offset_i),
      .wr_tag_en_i    (wr_tag_en_i),
      .wr_valid_en_i  (wr_valid_en_i),
      .wr_dirty_en_i  (wr_dirty_en_i),
      .wr_lru_en_i    (wr_lru_en_i),
      .wr_full_line_i (wr_full_line_i),
      .wr_data_en_i   (wr_data_en_i),
      .wr_tag_i       (wr_tag_i),
      .wr_valid_i     (wr_valid_i),
      .wr_dirty_i     (wr_dirty_i),
      .wr_lru_i       (wr_lru_i),
      .wr_data_i      (wr_data_i),
      .rd_tag_o       (rd_tag_o),
      .rd_valid_o     (rd_valid_o),
      .rd_dirty_o     (rd_dirty_o),
      .rd_lru_o       (rd_lru_o),
      .rd_data_o      (rd_data_o),
      .flush_req_i    (flush_req_i),
      .flush_wb_i     (flush_wb_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .wb_valid_o     (wb_valid_o),
      .wb_ready_i     (wb_ready_i),
      .wb_index_o     (wb_index_o),
      .wb_tag_o       (wb_tag_o),
      .wb_data_o      (wb_data_o)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_wr;
      wr_tag_en_i = 0; wr_valid_en_i = 0; wr_dirty_en_i = 0; wr_lru_en_i = 0;
      wr_full_line_i = 0; wr_data_en_i = '0;
   endtask

   task automatic wr_full(input int idx, input logic [19:0] tag, input logic [127:0] data,
                          input logic v, input logic d);
      index_i = 8'(idx);
      wr_tag_en_i = 1; wr_valid_en_i = 1; wr_dirty_en_i = 1; wr_lru_en_i = 1;
      wr_full_line_i = 1; wr_tag_i = tag; wr_valid_i = v; wr_dirty_i = d; wr_lru_i = 1;
      wr_data_i = data;
      tick;
      clear_wr;
   endtask

   task automatic rd(input int idx);
      index_i = 8'(idx);
      tick;
   endtask

   localparam logic [127:0] D5   = 128'h0000000D_0000000C_0000000B_0000000A;
   localparam logic [127:0] D5P  = 128'h0000000D_77777777_0000000B_0000000A;
   localparam logic [127:0] D3   = 128'h33330003_33330002_33330001_33330000;
   localparam logic [127:0] D200 = 128'hC8000003_C8000002_C8000001_C8000000;

   int           n_wb, n_done, n_busy, cyc, bad;
   logic [7:0]   idx_log [2];
   logic [19:0]  tag_log [2];
   logic [127:0] data_log [2];

   initial begin
      rst_n = 0; index_i = '0; offset_i = '0; clear_wr;
      wr_tag_i = '0; wr_valid_i = 0; wr_dirty_i = 0; wr_lru_i = 0; wr_data_i = '0;
      flush_req_i = 0; flush_wb_i = 0; wb_ready_i = 0;
      repeat (3) tick;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_wb_valid", wb_valid_o, 0);
      check("rst_rd_valid", rd_valid_o, 0);
      rst_n = 1;
      tick;

      // Full-line write then read back.
      wr_full(5, 20'h12345, D5, 1, 0);
      rd(5);
      check("rd5_tag", rd_tag_o, 20'h12345);
      check("rd5_valid", rd_valid_o, 1);
      check("rd5_dirty", rd_dirty_o, 0);
      check("rd5_lru", rd_lru_o, 1);
      check("rd5_data", rd_data_o, D5);

      // Partial write touches only word 2.
      index_i = 8'd5; offset_i = 2'd2; wr_full_line_i = 0; wr_data_en_i = 4'b0100;
      wr_data_i = 128'hFFFFFFFF_77777777_FFFFFFFF_FFFFFFFF;
      tick;
      clear_wr;
      rd(5);
      check("part_data", rd_data_o, D5P);
      check("part_tag", rd_tag_o, 20'h12345);

      // Same-cycle read/write returns old contents.
      wr_full(7, 20'h00111, '0, 1, 0);
      index_i = 8'd7; wr_tag_en_i = 1; wr_tag_i = 20'h00222; wr_valid_en_i = 1; wr_valid_i = 0;
      tick;
      clear_wr;
      check("rf_old_tag", rd_tag_o, 20'h00111);
      check("rf_old_valid", rd_valid_o, 1);
      rd(7);
      check("rf_new_tag", rd_tag_o, 20'h00222);
      check("rf_new_valid", rd_valid_o, 0);

      // Write-back flush: sets 3 and 200 dirty, set 5 clean.
      wr_full(3, 20'h00003, D3, 1, 1);
      wr_full(200, 20'hC8C8C, D200, 1, 1);
      flush_req_i = 1; flush_wb_i = 1;
      tick;
      flush_req_i = 0;
      check("wbf_busy", busy_o, 1);
      n_wb = 0; n_done = 0; cyc = 0;
      while (busy_o && cyc < 2000) begin
         if (done_o) n_done++;
         if (wb_valid_o) begin
            if (n_wb < 2) begin
               idx_log[n_wb] = wb_index_o; tag_log[n_wb] = wb_tag_o; data_log[n_wb] = wb_data_o;
            end
            if (n_wb == 0) begin
               bad = 0;
               for (int k = 0; k < 10; k++) begin
                  tick; cyc++;
                  if (wb_valid_o !== 1'b1 || wb_index_o !== idx_log[0] ||
                      wb_tag_o !== tag_log[0] || wb_data_o !== data_log[0]) bad++;
               end
               check("wb_hold_stable", bad, 0);
            end
            wb_ready_i = 1;
            tick; cyc++;
            wb_ready_i = 0;
            check("wb_drop_after_hs", wb_valid_o, 0);
            n_wb++;
         end else begin
            tick; cyc++;
         end
      end
      check("wbf_finished", busy_o, 0);
      check("wbf_count", n_wb, 2);
      check("wbf_idx0", idx_log[0], 8'd3);
      check("wbf_tag0", tag_log[0], 20'h00003);
      check("wbf_data0", data_log[0], D3);
      check("wbf_idx1", idx_log[1], 8'd200);
      check("wbf_tag1", tag_log[1], 20'hC8C8C);
      check("wbf_data1", data_log[1], D200);
      check("wbf_done_once", n_done, 1);
      bad = 0;
      foreach (idx_log[i]) begin
         rd(int'(idx_log[i]));
         if (rd_valid_o !== 1'b0 || rd_dirty_o !== 1'b0) bad++;
      end
      rd(5);
      if (rd_valid_o !== 1'b0) bad++;
      check("wbf_cleared", bad, 0);

      // Invalidate-only flush with every set valid.
      wr_valid_en_i = 1; wr_valid_i = 1;
      for (int i = 0; i < 256; i++) rd(i);
      clear_wr;
      flush_req_i = 1; flush_wb_i = 0;
      tick;
      flush_req_i = 0;
      n_busy = 0; n_done = 0; n_wb = 0;
      while (busy_o && n_busy < 20) begin
         n_busy++;
         if (done_o) n_done++;
         if (wb_valid_o) n_wb++;
         tick;
      end
      check("inv_busy_cycles", n_busy, 2);
      check("inv_done_once", n_done, 1);
      check("inv_no_wb", n_wb, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         rd(i);
         if (rd_valid_o !== 1'b0) bad++;
      end
      check("inv_all_clear", bad, 0);

      // Reset while set 3 waits in write-back.
      wr_full(3, 20'h00003, D3, 1, 1);
      wr_full(200, 20'hC8C8C, D200, 1, 1);
      flush_req_i = 1; flush_wb_i = 1;
      tick;
      flush_req_i = 0;
      cyc = 0;
      while (!wb_valid_o && cyc < 1000) begin
         tick; cyc++;
      end
      check("rst_mid_reach_wb", wb_valid_o, 1);
      check("rst_mid_idx", wb_index_o, 8'd3);
      #2 rst_n = 0;
      #1;
      check("rst_mid_wb_valid", wb_valid_o, 0);
      check("rst_mid_busy", busy_o, 0);
      tick;
      rst_n = 1;
      n_done = 0; n_busy = 0;
      for (int k = 0; k < 20; k++) begin
         tick;
         if (done_o) n_done++;
         if (busy_o) n_busy++;
      end
      check("rst_mid_no_done", n_done, 0);
      check("rst_mid_idle", n_busy, 0);
      rd(3);
      check("rst_mid_v3", rd_valid_o, 0);
      rd(200);
      check("rst_mid_v200", rd_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
